demux_1_8_deser: RTL and testbench
==================================

# demux_1_8_deser

Sequential 1-to-8 demultiplexer / serial-to-parallel capture register, the receive-side counterpart of the team's 8:1 select multiplexer. A serial bit stream on D is steered into eight registered outputs Y0..Y7. Steering is either by an external 3-bit select (S2,S1,S0) or by an internal slot counter that assembles complete 8-bit frames. It sits directly downstream of an 8:1 mux link and recovers the parallel word that the mux serialized.

## Interface
Parameters:
- None. Slot count is fixed at 8 and slot index width at 3; both are package constants.

Ports (one clock; reset is synchronous and active-low):
- CLK  input  1  rising-edge clock
- RSTN  input  1  synchronous active-low reset, sampled on CLK rising edge
- D  input  1  serial data bit
- EN  input  1  write strobe; D is consumed on any rising edge with EN=1
- AUTO  input  1  1 = framed mode (internal counter), 0 = direct mode (external select)
- S2, S1, S0  input  1 each  direct-mode slot address, S2 = MSB; ignored when AUTO=1
- Y0..Y7  output  1 each  registered parallel outputs; Y0 = slot 0
- CNT2, CNT1, CNT0  output  1 each  current framed-mode slot index, CNT2 = MSB
- BUSY  output  1  1 while a framed-mode frame is partially collected
- VALID  output  1  1-cycle pulse: Y0..Y7 now hold a new complete frame

## Operation
- Reset (RSTN=0 at an edge) forces the following regardless of other inputs:
  - Y0..Y7 = 0, CNT = 0, BUSY = 0, VALID = 0
  - FSM enters IDLE and the shadow register is cleared.
- FSM states:
  - IDLE: no partial frame.
  - COLLECT: slots 1..7 pending.
  - DONE: frame just delivered.
- Direct mode (AUTO=0):
  - On an EN edge, the output Y[{S2,S1,S0}] takes D. The other seven outputs hold.
  - FSM is held in IDLE, CNT = 0, BUSY = 0, VALID = 0.
- Framed mode (AUTO=1):
  - Each EN edge writes D into shadow[CNT], then CNT increments.
  - IDLE -> COLLECT on the first EN edge (slot 0 written, CNT becomes 1).
  - COLLECT holds across EN=0 cycles; there is no timeout.
  - The EN edge with CNT=7 does three things on the same edge: transfers shadow[6:0] plus D into Y7..Y0, wraps CNT to 0, and enters DONE.
  - Y0..Y7 do not change during collection (double-buffered).
  - DONE -> IDLE if EN=0. DONE -> COLLECT if EN=1; that EN bit is slot 0 of the next frame, so back-to-back frames carry no bubble.
- VALID = 1 exactly while in DONE (Moore output).
- BUSY = 1 exactly while in COLLECT.
- Mode changes:
  - AUTO falling while in COLLECT or DONE discards the partial frame: next state IDLE, CNT = 0, Y unchanged. An EN on that same edge is handled as a direct-mode write.
  - AUTO rising: the next EN edge is slot 0.
- Simultaneous events: reset has priority over EN and AUTO on the same edge.

## Timing
- All state and outputs are registered on the CLK rising edge. There are no combinational input-to-output paths.
- Direct-mode latency: Y valid 1 cycle after the EN edge.
- Framed-mode latency: Y0..Y7 and VALID update on the edge that captures slot 7. VALID stays high for one cycle.
- Throughput: one bit per cycle. An 8-bit frame every 8 EN cycles.
- CNT reflects the slot the next EN edge will write.

## Structure
Shared package:
- NSLOTS = 8, SLOT_W = 3
- FSM state enum {IDLE, COLLECT, DONE}
- Reset value constants for Y and CNT

Sub-module `slot_decoder_3_8`:
- 3-to-8 one-hot decoder with enable. It drives per-slot write enables from {S2,S1,S0} or CNT.
- The top level holds the FSM, the counter, the shadow register and the output register.

## Test plan
- Reset: hold RSTN=0 with EN=1, D=1, AUTO=1 for 3 cycles -> Y0..Y7 = 0, CNT = 0, BUSY = 0, VALID = 0 throughout.
- Direct mode: AUTO=0; write D=1 at S=3, then D=1 at S=6, then D=0 at S=3 -> Y = 01000000b (Y7..Y0) after the third write; VALID never asserts.
- Framed frame: AUTO=1; EN=1 for 8 cycles, D = 1,0,1,1,0,0,1,0 -> Y7..Y0 = 01001101b on the 8th edge; VALID = 1 for exactly one cycle; BUSY = 1 on cycles 2-8; Y unchanged before the 8th edge.
- Back-to-back with gaps: 16 EN cycles carrying 0xA5 then 0x3C (slot 0 first), with EN=0 gaps inserted mid-frame -> two VALID pulses, Y = A5h then 3Ch; the second frame's slot 0 is accepted in the DONE cycle.
- Abort: AUTO=1; 5 EN bits, then AUTO=0 for 1 cycle, then AUTO=1 and a full frame of 0xFF -> Y = FFh, exactly one VALID, and no stale bits from the aborted frame.
- Reset mid-frame: RSTN=0 after 4 framed bits -> on the next edge CNT = 0, BUSY = 0, Y = 0; a following 8-bit frame is delivered intact.

Source files
------------

// File: rtl/demux_1_8_deser_pkg.sv
// Shared constants and FSM state type for the 1-to-8 deserializing demultiplexer.
package demux_1_8_deser_pkg;

    localparam int unsigned NSLOTS = 8;
    localparam int unsigned SLOT_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [NSLOTS-1:0] Y_RST   = '0;
    localparam logic [SLOT_W-1:0] CNT_RST = '0;

endpackage

// File: rtl/demux_1_8_deser_slot_decoder_3_8.sv
// 3-to-8 one-hot decoder with enable; produces per-slot write strobes.
module slot_decoder_3_8
    import demux_1_8_deser_pkg::*;
(
    input  logic              en,
    input  logic [SLOT_W-1:0] sel,
    output logic [NSLOTS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_1_8_deser.sv
// Serial-to-parallel capture: direct-addressed writes or counter-framed 8-bit
// frames double-buffered through a shadow register.
module demux_1_8_deser
    import demux_1_8_deser_pkg::*;
(
    input  logic CLK,
    input  logic RSTN,
    input  logic D,
    input  logic EN,
    input  logic AUTO,
    input  logic S2,
    input  logic S1,
    input  logic S0,
    output logic Y0,
    output logic Y1,
    output logic Y2,
    output logic Y3,
    output logic Y4,
    output logic Y5,
    output logic Y6,
    output logic Y7,
    output logic CNT2,
    output logic CNT1,
    output logic CNT0,
    output logic BUSY,
    output logic VALID
);

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   cnt_q, cnt_d;
    logic [NSLOTS-2:0]   shadow_q, shadow_d;
    logic [NSLOTS-1:0]   y_q, y_d;
    logic [SLOT_W-1:0]   wr_sel;
    logic [NSLOTS-1:0]   wr_en;
    logic                last_slot;

    assign wr_sel    = AUTO ? cnt_q : {S2, S1, S0};
    assign last_slot = (cnt_q == SLOT_W'(NSLOTS - 1));

    slot_decoder_3_8 u_dec (
        .en     (EN),
        .sel    (wr_sel),
        .onehot (wr_en)
    );

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_RST;
            shadow_q <= '0;
            y_q      <= Y_RST;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            y_q      <= y_d;
        end
    end

    // Dropping AUTO aborts any partial frame; an EN on that edge is a direct write.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        y_d      = y_q;
        if (!AUTO) begin
            state_d = IDLE;
            cnt_d   = CNT_RST;
            y_d     = (y_q & ~wr_en) | ({NSLOTS{D}} & wr_en);
        end else if (EN) begin
            shadow_d = (shadow_q & ~wr_en[NSLOTS-2:0]) | ({(NSLOTS-1){D}} & wr_en[NSLOTS-2:0]);
            if (last_slot) begin
                y_d     = {D, shadow_q};
                cnt_d   = CNT_RST;
                state_d = DONE;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = COLLECT;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    assign {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} = y_q;
    assign {CNT2, CNT1, CNT0}               = cnt_q;
    assign BUSY                             = (state_q == COLLECT);
    assign VALID                            = (state_q == DONE);

endmodule

// File: tb/tb_demux_1_8_deser.sv
// Self-checking bench: directed scenarios plus random traffic against a frame-level model.
module tb_demux_1_8_deser;

    logic clk = 1'b0;
    logic rstn, d, en, mode_auto;
    logic [2:0] s;
    logic y0, y1, y2, y3, y4, y5, y6, y7;
    logic cnt2, cnt1, cnt0, busy, valid;
    logic [7:0] y;
    logic [2:0] cnt;

    int total = 0;
    int bad   = 0;
    int vcount = 0;

    // model: output word, partially assembled frame and its fill level
    logic [7:0] m_y;
    logic [7:0] m_part;
    int         m_n;
    logic       m_valid;

    always #5 clk = ~clk;

    assign y   = {y7, y6, y5, y4, y3, y2, y1, y0};
    assign cnt = {cnt2, cnt1, cnt0};

    demux_1_8_deser dut (
        .CLK(clk), .RSTN(rstn), .D(d), .EN(en), .AUTO(mode_auto),
        .S2(s[2]), .S1(s[1]), .S0(s[0]),
        .Y0(y0), .Y1(y1), .Y2(y2), .Y3(y3), .Y4(y4), .Y5(y5), .Y6(y6), .Y7(y7),
        .CNT2(cnt2), .CNT1(cnt1), .CNT0(cnt0), .BUSY(busy), .VALID(valid)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic a, input logic e,
                              input logic dd, input logic [2:0] sl);
        if (!r) begin
            m_y = '0; m_n = 0; m_valid = 1'b0; m_part = '0;
        end else if (!a) begin
            if (e) m_y[sl] = dd;
            m_n = 0; m_valid = 1'b0;
        end else if (e) begin
            m_part[m_n] = dd;
            m_n++;
            if (m_n == 8) begin
                m_y = m_part; m_n = 0; m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare();
        chk("y", y, m_y);
        chk("cnt", {5'd0, cnt}, 8'(m_n));
        chk("busy", {7'd0, busy}, {7'd0, (m_n > 0)});
        chk("valid", {7'd0, valid}, {7'd0, m_valid});
        if (valid === 1'b1) vcount++;
    endtask

    task automatic step(input logic r, input logic a, input logic e,
                        input logic dd, input logic [2:0] sl);
        rstn = r; mode_auto = a; en = e; d = dd; s = sl;
        @(posedge clk);
        model_edge(r, a, e, dd, sl);
        @(negedge clk);
        compare();
    endtask

    // framed byte, slot 0 first, with an EN=0 gap before slot `gap` (gap >= 8: none)
    task automatic send_frame(input logic [7:0] b, input int gap);
        for (int i = 0; i < 8; i++) begin
            if (i == gap) step(1, 1, 0, 1, 3'd0);
            step(1, 1, 1, b[i], 3'($urandom_range(7)));
        end
    endtask

    initial begin
        m_y = '0; m_part = '0; m_n = 0; m_valid = 1'b0;

        // reset held with active inputs
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 1, 3'd5);
            chk("rst_y", y, 8'h00);
            chk("rst_flags", {cnt, busy, valid}, 5'b0);
        end

        // direct mode
        vcount = 0;
        step(1, 0, 1, 1, 3'd3);
        step(1, 0, 1, 1, 3'd6);
        step(1, 0, 1, 0, 3'd3);
        chk("direct_y", y, 8'b0100_0000);
        chk("direct_vcount", 8'(vcount), 8'd0);

        // single frame
        step(0, 1, 0, 0, 3'd0);
        vcount = 0;
        send_frame(8'b0100_1101, 8);
        chk("frame_y", y, 8'b0100_1101);
        chk("frame_valid", {7'd0, valid}, 8'd1);
        step(1, 1, 0, 0, 3'd0);
        chk("frame_vcount", 8'(vcount), 8'd1);

        // back-to-back with mid-frame gaps
        vcount = 0;
        send_frame(8'hA5, 3);
        chk("b2b_first", y, 8'hA5);
        send_frame(8'h3C, 5);
        chk("b2b_second", y, 8'h3C);
        chk("b2b_vcount", 8'(vcount), 8'd2);

        // abort then full frame of ones
        step(1, 1, 0, 0, 3'd0);
        vcount = 0;
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 3'd0);
        step(1, 0, 0, 0, 3'd0);
        chk("abort_cnt", {5'd0, cnt}, 8'd0);
        send_frame(8'hFF, 8);
        chk("abort_y", y, 8'hFF);
        step(1, 1, 0, 0, 3'd0);
        chk("abort_vcount", 8'(vcount), 8'd1);

        // reset mid-frame
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 3'd0);
        step(0, 1, 1, 1, 3'd0);
        chk("midrst", {y, 3'b0, cnt, busy, valid}, 16'h0000);
        send_frame(8'h96, 8);
        chk("midrst_frame", y, 8'h96);

        // random traffic
        mode_auto = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic a;
            a = mode_auto;
            if ($urandom_range(99) < 4) a = ~a;
            step(($urandom_range(99) >= 2), a, 1'($urandom_range(1)),
                 1'($urandom_range(1)), 3'($urandom_range(7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
